// File: rtl/des_pkg.sv
// Shared DES tables, key-shift schedule and controller state encoding.
// Tables use FIPS 46-3 numbering: entries are 1-based source bit positions, bit 1 = MSB.
package des_pkg;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam int IP [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

   localparam int IP_INV [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
      26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
      51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam int E [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
      12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
      22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   // Each box is 4 rows of 16, so the flat index is {row, col}.
   localparam int SBOX [8][64] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

   // SHIFT[n-1] is the left-shift count that produces subkey Kn.
   localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Round rnd uses K(17-rnd); undoing its shift moves C/D back to K(16-rnd).
   function automatic logic shift_is_one(logic [4:0] rnd);
      logic [3:0] idx;
      idx = 4'(5'd16 - rnd);
      return SHIFT[idx] == 1;
   endfunction

endpackage

// File: rtl/des_decrypt_iter_if.sv
// Ciphertext-in / plaintext-out handshake bundle for the iterative DES decryptor.
interface des_decrypt_iter_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:64] ciphertext;
   logic [1:64] key;
   logic        out_valid;
   logic        out_ready;
   logic [1:64] plaintext;

   modport master (
      output in_valid, ciphertext, key, out_ready,
      input  in_ready, out_valid, plaintext
   );

   modport slave (
      input  in_valid, ciphertext, key, out_ready,
      output in_ready, out_valid, plaintext
   );
endinterface

// File: rtl/des_perm.sv
// Fixed DES bit permutations shared with the encryption path: IP, IP inverse and PC1.
module Initial_Permutation
   import des_pkg::*;
(
   input  logic [1:64] block,
   output logic [1:64] permuted
);
   for (genvar i = 1; i <= 64; i++) begin : g_bit
      assign permuted[i] = block[IP[i-1]];
   end
endmodule

module IP_inv
   import des_pkg::*;
(
   input  logic [1:64] block,
   output logic [1:64] permuted
);
   for (genvar i = 1; i <= 64; i++) begin : g_bit
      assign permuted[i] = block[IP_INV[i-1]];
   end
endmodule

module Permuted_Choice_1
   import des_pkg::*;
(
   input  logic [1:64] key,
   output logic [1:56] cd
);
   // Parity bits take no part in the key schedule.
   logic unused_parity;
   assign unused_parity = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};

   for (genvar i = 1; i <= 56; i++) begin : g_bit
      assign cd[i] = key[PC1[i-1]];
   end
endmodule

// File: rtl/des_round_f.sv
// DES round function f(R,K) = P(S1..S8(E(R) ^ K)), purely combinational.
module des_round_f
   import des_pkg::*;
(
   input  logic [1:32] r,
   input  logic [1:48] k,
   output logic [1:32] f
);
   logic [1:48] x;
   logic [1:32] s;

   for (genvar i = 1; i <= 48; i++) begin : g_e
      assign x[i] = r[E[i-1]] ^ k[i];
   end

   // Row from group bits 1 and 6, column from bits 2..5.
   for (genvar g = 0; g < 8; g++) begin : g_sbox
      logic [5:0] six;
      logic [5:0] idx;
      assign six = x[6*g+1 : 6*g+6];
      assign idx = {six[5], six[0], six[4:1]};
      assign s[4*g+1 : 4*g+4] = 4'(SBOX[g][idx]);
   end

   for (genvar i = 1; i <= 32; i++) begin : g_p
      assign f[i] = s[P[i-1]];
   end
endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock, key schedule walked K16 down to K1.
//  state | meaning
//  IDLE  | waiting for a block, in_ready high
//  ROUND | one round per clock, rnd = 1..16 uses subkey K(17-rnd)
//  DONE  | plaintext presented, held until the consumer takes it
module des_decrypt_iter
   import des_pkg::*;
(
   input logic               clk,
   input logic               rst,
   des_decrypt_iter_if.slave bus
);
   state_t      state_q, state_d;
   logic [1:32] l_q, r_q;
   logic [1:28] c_q, d_q;
   logic [4:0]  rnd_q;
   logic [1:64] pt_q;

   logic [1:64] ip_out, preout, ipinv_out;
   logic [1:56] pc1_out;
   logic [1:48] subkey;
   logic [1:32] f_out, r_next;
   logic [1:28] c_next, d_next;
   logic        shift_one;

   Initial_Permutation u_ip    (.block(bus.ciphertext), .permuted(ip_out));
   Permuted_Choice_1   u_pc1   (.key(bus.key), .cd(pc1_out));
   IP_inv              u_ipinv (.block(preout), .permuted(ipinv_out));
   des_round_f         u_f     (.r(r_q), .k(subkey), .f(f_out));

   for (genvar i = 1; i <= 48; i++) begin : g_pc2
      if (PC2[i-1] <= 28) begin : g_c
         assign subkey[i] = c_q[PC2[i-1]];
      end else begin : g_d
         assign subkey[i] = d_q[PC2[i-1]-28];
      end
   end

   assign r_next    = l_q ^ f_out;
   assign preout    = {r_next, r_q};
   assign shift_one = shift_is_one(rnd_q);

   // Right rotation undoes the encryption-side left shifts one round at a time.
   assign c_next = shift_one ? {c_q[28], c_q[1:27]} : {c_q[27:28], c_q[1:26]};
   assign d_next = shift_one ? {d_q[28], d_q[1:27]} : {d_q[27:28], d_q[1:26]};

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = ROUND;
         end
         ROUND: begin
            if (rnd_q == 5'd16) state_d = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         rnd_q   <= '0;
         pt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.in_valid) begin
            l_q   <= ip_out[1:32];
            r_q   <= ip_out[33:64];
            c_q   <= pc1_out[1:28];
            d_q   <= pc1_out[29:56];
            rnd_q <= 5'd1;
         end else if (state_q == ROUND) begin
            l_q <= r_q;
            r_q <= r_next;
            c_q <= c_next;
            d_q <= d_next;
            if (rnd_q == 5'd16) pt_q  <= ipinv_out;
            else                rnd_q <= rnd_q + 5'd1;
         end
      end
   end

   assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed and round-trip bench for des_decrypt_iter against a forward-key-schedule DES model.
module tb_des_decrypt_iter;
   logic clk;
   logic rst;
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;
   logic [63:0] exp_q [$];

   des_decrypt_iter_if bus ();
   des_decrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // Reference tables, 1-based source bit positions; shorter tables zero padded.
   int t_ip [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
   int t_ipinv [64];
   int t_pc1 [64] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                      63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4,0,0,0,0,0,0,0,0};
   int t_pc2 [64] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                      41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32,
                      0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
   int t_e [64]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,
                      22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
   int t_p [64]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25,
                      0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
   int t_sh [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   int t_sb [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   // Values are right aligned; bit n (1 = MSB) of a w-bit value is v[w-n].
   function automatic logic [63:0] perm(logic [63:0] v, int w, int tbl [64], int n);
      logic [63:0] o = '0;
      for (int i = 0; i < n; i++) o = {o[62:0], v[w - tbl[i]]};
      return o;
   endfunction

   function automatic logic [31:0] f_model(logic [31:0] r, logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s = '0;
      logic [5:0]  six;
      int          idx;
      x = 48'(perm({32'h0, r}, 32, t_e, 48)) ^ k;
      for (int j = 0; j < 8; j++) begin
         six = x[47 - 6*j -: 6];
         idx = 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1]);
         s   = {s[27:0], 4'(t_sb[j][idx])};
      end
      return 32'(perm({32'h0, s}, 32, t_p, 32));
   endfunction

   function automatic logic [63:0] des_model(logic [63:0] blk, logic [63:0] key, bit decrypt);
      logic [47:0] ks [16];
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [63:0] lr;
      logic [31:0] l, r, t;
      cd = 56'(perm(key, 64, t_pc1, 56));
      c  = cd[55:28];
      d  = cd[27:0];
      for (int i = 0; i < 16; i++) begin
         for (int s = 0; s < t_sh[i]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         ks[i] = 48'(perm({8'h0, c, d}, 56, t_pc2, 48));
      end
      lr = perm(blk, 64, t_ip, 64);
      l  = lr[63:32];
      r  = lr[31:0];
      for (int i = 0; i < 16; i++) begin
         t = r;
         r = l ^ f_model(r, decrypt ? ks[15-i] : ks[i]);
         l = t;
      end
      return perm({r, l}, 64, t_ipinv, 64);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every cycle the DUT presents plaintext it must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         chk("ready_while_valid", bus.in_ready, 1'b0);
         if (exp_q.size() == 0) chk("spurious_out_valid", bus.out_valid, 1'b0);
         else begin
            chk("plaintext", bus.plaintext, exp_q[0]);
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [63:0] ct, input logic [63:0] k, input logic [63:0] exp, output int acc);
      bit ok;
      int n = 0;
      bus.in_valid   = 1'b1;
      bus.ciphertext = ct;
      bus.key        = k;
      do begin
         ok = bus.in_ready;
         tick();
         n++;
      end while (!ok && n < 25);
      bus.in_valid = 1'b0;
      chk("accept", ok, 1'b1);
      if (ok) exp_q.push_back(exp);
      acc = cyc;
   endtask

   task automatic wait_out(input bit scramble);
      int lat = 0;
      bit seen = 0;
      bit busy_rdy = 0;
      while (!seen && lat < 25) begin
         if (scramble) begin
            bus.ciphertext = {$urandom, $urandom};
            bus.key        = {$urandom, $urandom};
         end
         tick();
         lat++;
         if (bus.in_ready) busy_rdy = 1;
         if (bus.out_valid) seen = 1;
      end
      chk("latency", lat, 16);
      chk("busy_in_ready", busy_rdy, 1'b0);
   endtask

   task automatic run_block(input logic [63:0] ct, input logic [63:0] k, input logic [63:0] exp, input bit scramble);
      int acc;
      send(ct, k, exp, acc);
      wait_out(scramble);
      tick();
      chk("in_ready_at_t17", bus.in_ready, 1'b1);
      chk("out_valid_at_t17", bus.out_valid, 1'b0);
      chk("idle_cycles", cyc - acc, 17);
   endtask

   localparam logic [63:0] K_STD  = 64'h133457799BBCDFF1;
   localparam logic [63:0] CT_STD = 64'h85E813540F0AB405;
   localparam logic [63:0] PT_STD = 64'h0123456789ABCDEF;
   localparam logic [63:0] K_V2   = 64'h0E329232EA6D0D73;
   localparam logic [63:0] PT_V2  = 64'h8787878787878787;

   initial begin
      logic [63:0] k, ct, pt;
      int acc;
      for (int i = 0; i < 64; i++) t_ipinv[t_ip[i]-1] = i + 1;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.ciphertext = '0;
      bus.key = '0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_plaintext", bus.plaintext, 64'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", bus.in_ready, 1'b1);

      chk("model_std_dec", des_model(CT_STD, K_STD, 1'b1), PT_STD);
      chk("model_std_enc", des_model(PT_STD, K_STD, 1'b0), CT_STD);
      chk("model_v2_dec", des_model(64'h0, K_V2, 1'b1), PT_V2);

      bus.out_ready = 1'b1;
      run_block(CT_STD, K_STD, PT_STD, 1'b0);
      run_block(64'h0, K_V2, PT_V2, 1'b0);
      for (int j = 0; j < 8; j++) begin
         k = K_V2 ^ (64'h1 << (8*j));
         run_block(64'h0, k, PT_V2, 1'b0);
      end

      // Backpressure with a competing request held on the input side.
      bus.out_ready = 1'b0;
      send(CT_STD, K_STD, PT_STD, acc);
      wait_out(1'b0);
      bus.in_valid   = 1'b1;
      bus.ciphertext = 64'hFEDCBA9876543210;
      bus.key        = K_V2;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_out_valid", bus.out_valid, 1'b1);
         chk("bp_in_ready", bus.in_ready, 1'b0);
         chk("bp_plaintext", bus.plaintext, PT_STD);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_no_accept", bus.out_valid, 1'b0);
         chk("idle_holds_plaintext", bus.plaintext, PT_STD);
      end
      chk("bp_queue_empty", 64'(exp_q.size()), 64'h0);

      // Inputs change every cycle after accept; only the captured pair matters.
      ct = {$urandom, $urandom};
      k  = {$urandom, $urandom};
      run_block(ct, k, des_model(ct, k, 1'b1), 1'b1);

      // Abort in round 8; nothing may come out of the aborted block.
      send(CT_STD, K_V2, des_model(CT_STD, K_V2, 1'b1), acc);
      repeat (7) tick();
      rst = 1'b1;
      exp_q.delete();
      tick();
      chk("abort_in_ready", bus.in_ready, 1'b1);
      chk("abort_out_valid", bus.out_valid, 1'b0);
      chk("abort_plaintext", bus.plaintext, 64'h0);
      rst = 1'b0;
      run_block(CT_STD, K_STD, PT_STD, 1'b0);

      // Round trip: plaintext encrypted by the model, decrypted by the DUT.
      for (int n = 0; n < 1000; n++) begin
         k  = {$urandom, $urandom};
         pt = {$urandom, $urandom};
         ct = des_model(pt, k, 1'b0);
         run_block(ct, k, pt, 1'b0);
         if (fails > 50) break;
      end
      repeat (3) tick();
      chk("final_queue_empty", 64'(exp_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/des_decrypt_iter.md
# des_decrypt_iter

Iterative DES decryption core: accepts one 64-bit ciphertext block and a 64-bit key over a valid/ready handshake, runs the 16 Feistel rounds one per clock with the key schedule walked in reverse (K16 down to K1), and returns the recovered plaintext over a second valid/ready handshake. It is the sequential receive-side counterpart to the combinational encryption path. It sits after the ciphertext source and before the plaintext consumer, trading 16-cycle latency for one shared round datapath.

## Interface
- No parameters. DES widths are fixed at block 64, key 64, effective key 56, half-key 28, subkey 48.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext and key are valid
- in_ready  out  1  core can accept a block
- ciphertext  in  [1:64]  input block; bit 1 is MSB, FIPS 46-3 numbering
- key  in  [1:64]  DES key including parity bits; parity bits 8, 16, …, 64 are ignored
- out_valid  out  1  plaintext is valid
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  [1:64]  decrypted block, bit 1 is MSB

## Operation
- FSM states:
  - IDLE: in_ready=1. An in_valid&in_ready edge loads {L,R}=IP(ciphertext) and {C,D}=PC1(key), clears the round counter rnd to 1, and moves to ROUND.
  - ROUND: one round per edge.
    - Subkey is PC2(C,D), which equals K(17−rnd). Round 1 uses {C0,D0} unrotated, since 28 total left shifts make K16 use C0/D0.
    - Update: L←R, R←L ^ f(R, subkey).
    - Then C and D each rotate right by shift(17−rnd), where shift(n)=1 for n∈{1,2,9,16} and 2 otherwise.
    - After the edge with rnd=16, go to DONE. Otherwise rnd←rnd+1.
  - DONE: out_valid=1 and plaintext=IP⁻¹({R,L}) (final swap). An out_valid&out_ready edge moves to IDLE.
- f(R,K) = P(S1..S8(E(R) ^ K)), with S-box row = bits 1,6 and column = bits 2–5 of each 6-bit group.
- Inputs are captured at accept. Later changes to ciphertext/key have no effect on the block in flight.
- in_ready=0 in ROUND and DONE. No new block is accepted until the result is consumed.
- in_valid while busy is ignored (held by the producer).
- In DONE, plaintext is held stable while out_ready=0, for any number of cycles.
- Weak and semi-weak keys receive no special handling.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, plaintext=64'h0, rnd=0, L/R/C/D cleared.
- rst has priority over every handshake. rst asserted in ROUND or DONE aborts the block with no output.
- Latency: for an accept edge at cycle t, out_valid rises after edge t+16.
- The consumer sees out_valid first in cycle t+16.
- With out_ready held high, the return to IDLE occurs at edge t+17.
- Then in_ready=1 in cycle t+17, so minimum spacing between accepts is 17 cycles.
- plaintext is registered: it is driven from a register loaded at the round-16 edge, not from a combinational path off L/R.
- plaintext holds its last value in IDLE.
- in_ready and out_valid are pure functions of state, with no combinational path from in_valid or out_ready.

## Structure
- Package des_pkg holds:
  - permutation tables IP, IP_INV, PC1, PC2, E, P
  - the eight S-box tables
  - the SHIFT schedule constant
  - the state enum {IDLE, ROUND, DONE}
- Reuse the existing combinational Initial_Permutation, IP_inv and Permuted_Choice_1 modules for IP, IP⁻¹ and PC1.
- New sub-module des_round_f: combinational f-function with inputs R[1:32] and K[1:48], output [1:32]. Instantiate it once.
- PC2 and the reverse rotation stay in the top as wiring plus a mux on the 1/2 shift amount.

## Test plan
- Standard vector: key 133457799BBCDFF1, ciphertext 85E813540F0AB405.
  - Required: plaintext 0123456789ABCDEF.
  - out_valid first high exactly 16 cycles after the accept edge.
- Second vector: key 0E329232EA6D0D73, ciphertext 0000000000000000.
  - Required: plaintext 8787878787878787.
  - Flipping any key parity bit gives the same result.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE. plaintext and out_valid stay stable, and in_ready stays 0.
  - A new in_valid with different data during that time is not accepted.
- Capture isolation: change ciphertext and key every cycle after accept. The output still equals decryption of the captured values.
- Reset mid-operation:
  - Assert rst at round 8. Next cycle: in_ready=1, out_valid=0, plaintext=0.
  - A fresh block afterward decrypts correctly with full 16-cycle latency.
- Round-trip: 1000 random key/plaintext pairs encrypted by the combinational encryption path or a reference model, then fed back-to-back.
  - Every output matches the original plaintext.
  - Accept spacing is exactly 17 cycles with out_ready=1.
